// File: rtl/mips_sim_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset simulator: opcodes, functs, FSM states, ALU ops.
// Pure declarations; no latency or flow control.
package mips_sim_pkg;

    localparam int INSTR_NUM_DEF = 256;
    localparam int DATA_NUM_DEF  = 256;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_t;

    // Instruction class decides the EXEC successor and the retiring state.
    typedef enum logic [2:0] {
        CL_NOP, CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_HALT
    } instr_cls_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the multi-cycle simulator; shifts operate on b by shamt.
// Zero latency, no flow control.
module mips_alu
    import mips_sim_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_multicycle_sim.sv
// Multi-cycle MIPS-subset simulator: FETCH/DECODE/EXEC/MEM/WB FSM over internal instruction/data memories.
// 3-5 cycles per instruction; start is honoured only in IDLE and HALT is left only through reset.
module mips_multicycle_sim
    import mips_sim_pkg::*;
#(
    parameter int INSTR_NUM = INSTR_NUM_DEF,
    parameter int DATA_NUM  = DATA_NUM_DEF,
    parameter int CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [31:0]      pc_o,
    output logic [CNT_W-1:0] retired_o,
    output logic [CNT_W-1:0] cycles_o
);

    localparam int IA_W = (INSTR_NUM > 1) ? $clog2(INSTR_NUM) : 1;
    localparam int DA_W = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

    logic [31:0] Instr_Mem [0:INSTR_NUM-1];
    logic [31:0] Data_Mem  [0:DATA_NUM-1];
    logic [31:0] Reg_File  [0:31];

    state_t           state, next_state;
    logic [31:0]      pc, ir, a, b, alu_out, mdr;
    logic             load_ok, fault, retire;
    logic [CNT_W-1:0] retired, cycles;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext;

    assign opcode  = ir[31:26];
    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign rd      = ir[15:11];
    assign shamt   = ir[10:6];
    assign funct   = ir[5:0];
    assign imm_ext = {{16{ir[15]}}, ir[15:0]};

    instr_cls_t  cls;
    alu_op_t     alu_op;
    logic        use_imm;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        alu_zero;

    always_comb begin
        cls     = CL_NOP;
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        dest    = rd;
        case (opcode)
            OP_RTYPE: begin
                cls = CL_ALU;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: cls    = CL_NOP;
                endcase
            end
            OP_ADDI: begin cls = CL_ALU; use_imm = 1'b1; dest = rt; end
            OP_SLTI: begin cls = CL_ALU; alu_op = ALU_SLT; use_imm = 1'b1; dest = rt; end
            OP_LW:   begin cls = CL_LW; use_imm = 1'b1; dest = rt; end
            OP_SW:   begin cls = CL_SW; use_imm = 1'b1; end
            OP_BEQ:  begin cls = CL_BEQ; alu_op = ALU_SUB; end
            OP_BNE:  begin cls = CL_BNE; alu_op = ALU_SUB; end
            OP_J:    cls = CL_J;
            OP_HALT: cls = CL_HALT;
            default: ;
        endcase
    end

    mips_alu u_alu (
        .op     (alu_op),
        .a      (a),
        .b      (use_imm ? imm_ext : b),
        .shamt  (shamt),
        .result (alu_result),
        .zero   (alu_zero)
    );

    logic pc_bad, mem_bad;
    assign pc_bad  = (pc[1:0] != 2'b00) || ((pc >> 2) >= 32'(INSTR_NUM));
    assign mem_bad = (alu_out[1:0] != 2'b00) || ((alu_out >> 2) >= 32'(DATA_NUM));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            ST_IDLE:   if (start_i) next_state = ST_FETCH;
            ST_FETCH:  next_state = pc_bad ? ST_HALT : ST_DECODE;
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC: begin
                case (cls)
                    CL_ALU:       next_state = ST_WB;
                    CL_LW, CL_SW: next_state = ST_MEM;
                    CL_HALT:      begin next_state = ST_HALT;  retire = 1'b1; end
                    default:      begin next_state = ST_FETCH; retire = 1'b1; end
                endcase
            end
            ST_MEM: begin
                next_state = (cls == CL_LW) ? ST_WB : ST_FETCH;
                retire     = (cls == CL_SW);
            end
            ST_WB: begin
                next_state = ST_FETCH;
                retire     = 1'b1;
            end
            default: ;
        endcase
    end

    // All architectural state, including both memories except Instr_Mem, is cleared by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            load_ok <= 1'b0;
            fault   <= 1'b0;
            retired <= '0;
            cycles  <= '0;
            for (int i = 0; i < 32; i++) Reg_File[i] <= '0;
            for (int i = 0; i < DATA_NUM; i++) Data_Mem[i] <= '0;
        end else begin
            if (busy_o) cycles <= cycles + CNT_W'(1);
            if (retire) retired <= retired + CNT_W'(1);
            case (state)
                ST_FETCH: begin
                    if (pc_bad) begin
                        fault <= 1'b1;
                    end else begin
                        ir <= Instr_Mem[pc[IA_W+1:2]];
                        pc <= pc + 32'd4;
                    end
                end
                ST_DECODE: begin
                    a <= Reg_File[rs];
                    b <= Reg_File[rt];
                end
                ST_EXEC: begin
                    alu_out <= alu_result;
                    // pc already points past this instruction, so it is the branch base
                    if ((cls == CL_BEQ && alu_zero) || (cls == CL_BNE && !alu_zero))
                        pc <= pc + (imm_ext << 2);
                    else if (cls == CL_J)
                        pc <= {pc[31:28], ir[25:0], 2'b00};
                end
                ST_MEM: begin
                    load_ok <= !mem_bad;
                    if (mem_bad)
                        fault <= 1'b1;
                    else if (cls == CL_LW)
                        mdr <= Data_Mem[alu_out[DA_W+1:2]];
                    else
                        Data_Mem[alu_out[DA_W+1:2]] <= b;
                end
                ST_WB: begin
                    if (dest != 5'd0 && (cls != CL_LW || load_ok))
                        Reg_File[dest] <= (cls == CL_LW) ? mdr : alu_out;
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (state != ST_IDLE) && (state != ST_HALT);
    assign halted_o  = (state == ST_HALT);
    assign fault_o   = fault;
    assign pc_o      = pc;
    assign retired_o = retired;
    assign cycles_o  = cycles;

endmodule

// File: tb/tb_mips_multicycle_sim.sv
// Self-checking bench for mips_multicycle_sim: ALU vector table, directed programs, and random
// programs checked against an instruction-level reference model.
module tb_mips_multicycle_sim;
    import mips_sim_pkg::*;

    localparam int IN = 256;
    localparam int DN = 256;
    localparam int RN = 24;
    localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

    logic        clk, rst, start;
    logic        busy, halted, fault;
    logic [31:0] pc, retired, cycles;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_sim #(.INSTR_NUM(IN), .DATA_NUM(DN), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .halted_o(halted),
        .fault_o(fault), .pc_o(pc), .retired_o(retired), .cycles_o(cycles)
    );

    logic [31:0] prog [0:IN-1];

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          a;
        int          b;
        logic [31:0] exp_r3;
        logic [31:0] exp_cyc;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt, input int sh);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, tgt[25:0]};
    endfunction

    task automatic set_vec(input int k, input string nm, input logic [31:0] ins, input int va, input int vb,
                           input logic [31:0] r3, input logic [31:0] cyc);
        vecs[k].name = nm; vecs[k].instr = ins; vecs[k].a = va; vecs[k].b = vb;
        vecs[k].exp_r3 = r3; vecs[k].exp_cyc = cyc;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < IN; i++) prog[i] = '0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < IN; i++) dut.Instr_Mem[i] = prog[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_prog(input bit hold, input int budget, output bit done, output bit busy1);
        done  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        busy1 = busy;
        if (!hold) start = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (halted) done = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Instruction-level reference: architectural effect plus the documented cost of each instruction.
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:DN-1];
    logic [31:0] m_pc, m_ret, m_cyc;
    logic        m_fault;

    task automatic model_run();
        logic [31:0] ins, va, vb, imm, addr, res;
        bit          done, wr, ok;
        int          dst;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < DN; i++) m_mem[i] = '0;
        m_pc = '0; m_ret = '0; m_cyc = '0; m_fault = 1'b0; done = 1'b0;
        for (int step = 0; step < 5000 && !done; step++) begin
            if (m_pc[1:0] != 2'b00 || m_pc / 4 >= IN) begin
                m_fault = 1'b1; m_cyc += 1; done = 1'b1;
            end else begin
                ins = prog[m_pc / 4];
                m_pc += 4; m_ret += 1;
                va  = m_reg[ins[25:21]];
                vb  = m_reg[ins[20:16]];
                imm = {{16{ins[15]}}, ins[15:0]};
                addr = va + imm;
                ok  = (addr[1:0] == 2'b00) && (addr / 4 < DN);
                wr = 1'b0; dst = ins[20:16]; res = '0;
                case (ins[31:26])
                    6'h00: begin
                        m_cyc += 4; wr = 1'b1; dst = ins[15:11];
                        case (ins[5:0])
                            6'h20: res = va + vb;
                            6'h22: res = va - vb;
                            6'h24: res = va & vb;
                            6'h25: res = va | vb;
                            6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                            6'h00: res = vb << ins[10:6];
                            6'h02: res = vb >> ins[10:6];
                            default: begin wr = 1'b0; m_cyc -= 1; end
                        endcase
                    end
                    6'h08: begin m_cyc += 4; wr = 1'b1; res = va + imm; end
                    6'h0A: begin m_cyc += 4; wr = 1'b1; res = ($signed(va) < $signed(imm)) ? 32'd1 : 32'd0; end
                    6'h23: begin
                        m_cyc += 5;
                        if (ok) begin wr = 1'b1; res = m_mem[addr / 4]; end
                        else m_fault = 1'b1;
                    end
                    6'h2B: begin
                        m_cyc += 4;
                        if (ok) m_mem[addr / 4] = vb;
                        else m_fault = 1'b1;
                    end
                    6'h04: begin m_cyc += 3; if (va == vb) m_pc += imm * 4; end
                    6'h05: begin m_cyc += 3; if (va != vb) m_pc += imm * 4; end
                    6'h02: begin m_cyc += 3; m_pc = {m_pc[31:28], ins[25:0], 2'b00}; end
                    6'h3F: begin m_cyc += 3; done = 1'b1; end
                    default: m_cyc += 3;
                endcase
                if (wr && dst != 0) m_reg[dst] = res;
            end
        end
    endtask

    function automatic int rand_mem_off();
        case ($urandom_range(0, 9))
            7:       return 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            8:       return -4;
            9:       return 1024;
            default: return 4 * $urandom_range(0, 15);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          done, b1, reached;
        logic [5:0]  fns [8];
        fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, 6'h3F};
        rst = 1'b0; start = 1'b0;

        do_reset();
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_pc", pc, 0);
        check("rst_retired", retired, 0);
        repeat (3) @(negedge clk);
        check("idle_cycles", cycles, 0);

        set_vec(0,  "add",    enc_r(FN_ADD, 3, 1, 2, 0), 5, -3, 32'd2, 32'd15);
        set_vec(1,  "sub",    enc_r(FN_SUB, 3, 1, 2, 0), 5, -3, 32'd8, 32'd15);
        set_vec(2,  "and",    enc_r(FN_AND, 3, 1, 2, 0), 12, 10, 32'd8, 32'd15);
        set_vec(3,  "or",     enc_r(FN_OR, 3, 1, 2, 0), 12, 10, 32'd14, 32'd15);
        set_vec(4,  "slt_t",  enc_r(FN_SLT, 3, 1, 2, 0), -3, 5, 32'd1, 32'd15);
        set_vec(5,  "slt_f",  enc_r(FN_SLT, 3, 1, 2, 0), 5, -3, 32'd0, 32'd15);
        set_vec(6,  "sll",    enc_r(FN_SLL, 3, 0, 2, 4), 0, 3, 32'd48, 32'd15);
        set_vec(7,  "srl",    enc_r(FN_SRL, 3, 0, 2, 4), 0, -16, 32'h0FFF_FFFF, 32'd15);
        set_vec(8,  "slti",   enc_i(OP_SLTI, 1, 3, -2), -7, 0, 32'd1, 32'd15);
        set_vec(9,  "addi",   enc_i(OP_ADDI, 1, 3, -150), 100, 0, 32'hFFFF_FFCE, 32'd15);
        set_vec(10, "bad_fn", enc_r(6'h3F, 3, 1, 2, 0), 1, 2, 32'd0, 32'd14);
        set_vec(11, "bad_op", enc_i(6'h3E, 1, 3, 5), 1, 2, 32'd0, 32'd14);

        for (int k = 0; k < 12; k++) begin
            clear_prog();
            prog[0] = enc_i(OP_ADDI, 0, 1, vecs[k].a);
            prog[1] = enc_i(OP_ADDI, 0, 2, vecs[k].b);
            prog[2] = vecs[k].instr;
            prog[3] = HALT_W;
            do_reset(); load_prog();
            run_prog(1'b0, 200, done, b1);
            check({vecs[k].name, "_done"}, 32'(done), 32'd1);
            check({vecs[k].name, "_r3"}, dut.Reg_File[3], vecs[k].exp_r3);
            check({vecs[k].name, "_cycles"}, cycles, vecs[k].exp_cyc);
            check({vecs[k].name, "_retired"}, retired, 32'd4);
        end

        // arithmetic program
        clear_prog();
        prog[0] = enc_i(OP_ADDI, 0, 1, 5);
        prog[1] = enc_i(OP_ADDI, 0, 2, -3);
        prog[2] = enc_r(FN_SUB, 3, 1, 2, 0);
        prog[3] = enc_r(FN_SLT, 4, 2, 1, 0);
        prog[4] = enc_r(FN_SLL, 5, 0, 1, 2);
        prog[5] = HALT_W;
        do_reset(); load_prog();
        run_prog(1'b0, 200, done, b1);
        check("arith_busy_after_start", 32'(b1), 32'd1);
        check("arith_done", 32'(done), 32'd1);
        check("arith_busy_at_halt", 32'(busy), 32'd0);
        check("arith_r3", dut.Reg_File[3], 32'd8);
        check("arith_r4", dut.Reg_File[4], 32'd1);
        check("arith_r5", dut.Reg_File[5], 32'd20);
        check("arith_retired", retired, 32'd6);
        check("arith_cycles", cycles, 32'd23);
        check("arith_pc", pc, 32'd24);
        check("arith_fault", 32'(fault), 32'd0);

        // $0 protection
        clear_prog();
        prog[0] = enc_i(OP_ADDI, 0, 0, 7);
        prog[1] = enc_r(FN_ADD, 8, 0, 0, 0);
        prog[2] = HALT_W;
        do_reset(); load_prog();
        run_prog(1'b0, 200, done, b1);
        check("zero_r8", dut.Reg_File[8], 32'd0);
        check("zero_r0", dut.Reg_File[0], 32'd0);

        // control flow: BNE loop, taken BEQ, forward J
        clear_prog();
        prog[0] = enc_i(OP_ADDI, 0, 1, 3);
        prog[1] = enc_i(OP_ADDI, 2, 2, 1);
        prog[2] = enc_i(OP_ADDI, 1, 1, -1);
        prog[3] = enc_i(OP_BNE, 1, 0, -3);
        prog[4] = enc_i(OP_BEQ, 1, 0, 1);
        prog[5] = enc_i(OP_ADDI, 0, 9, 99);
        prog[6] = enc_j(8);
        prog[7] = enc_i(OP_ADDI, 0, 9, 77);
        prog[8] = HALT_W;
        do_reset(); load_prog();
        run_prog(1'b0, 300, done, b1);
        check("ctl_pc", pc, 32'd36);
        check("ctl_loop_count", dut.Reg_File[2], 32'd3);
        check("ctl_r1", dut.Reg_File[1], 32'd0);
        check("ctl_skipped", dut.Reg_File[9], 32'd0);
        check("ctl_retired", retired, 32'd13);
        check("ctl_cycles", cycles, 32'd46);

        // PC run-off: every word is SLL $0 which retires as a 4-cycle write to $0
        clear_prog();
        do_reset(); load_prog();
        run_prog(1'b0, 2000, done, b1);
        check("runoff_done", 32'(done), 32'd1);
        check("runoff_fault", 32'(fault), 32'd1);
        check("runoff_pc", pc, 32'd1024);
        check("runoff_retired", retired, 32'd256);
        check("runoff_cycles", cycles, 32'd1025);

        // memory program, with an unaligned load that must be suppressed
        clear_prog();
        prog[0] = enc_i(OP_ADDI, 0, 1, 5);
        prog[1] = enc_i(OP_SW, 0, 1, 8);
        prog[2] = enc_i(OP_LW, 0, 6, 8);
        prog[3] = enc_i(OP_LW, 0, 7, 2);
        prog[4] = HALT_W;
        do_reset(); load_prog();
        run_prog(1'b0, 200, done, b1);
        check("mem_dmem2", dut.Data_Mem[2], 32'd5);
        check("mem_r6", dut.Reg_File[6], 32'd5);
        check("mem_r7", dut.Reg_File[7], 32'd0);
        check("mem_fault", 32'(fault), 32'd1);
        check("mem_halted", 32'(halted), 32'd1);
        check("mem_retired", retired, 32'd5);
        check("mem_cycles", cycles, 32'd21);

        // reset in the middle of the first LW
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            if (cycles == 32'd10) reached = 1'b1;
            else @(negedge clk);
        end
        check("midlw_reached", 32'(reached), 32'd1);
        rst = 1'b0;
        #1;
        check("midlw_busy", 32'(busy), 0);
        check("midlw_halted", 32'(halted), 0);
        check("midlw_fault", 32'(fault), 0);
        check("midlw_pc", pc, 0);
        check("midlw_retired", retired, 0);
        check("midlw_cycles", cycles, 0);
        check("midlw_r1", dut.Reg_File[1], 0);
        check("midlw_dmem2", dut.Data_Mem[2], 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // rerun with start held high throughout
        run_prog(1'b1, 200, done, b1);
        check("rerun_done", 32'(done), 32'd1);
        check("rerun_retired", retired, 32'd5);
        check("rerun_cycles", cycles, 32'd21);
        repeat (3) @(negedge clk);
        check("rerun_stay_halted", 32'(halted), 32'd1);
        check("rerun_retired_hold", retired, 32'd5);
        start = 1'b0;

        // random forward-only programs against the reference model
        for (int r = 0; r < 8; r++) begin
            clear_prog();
            for (int i = 0; i < RN; i++) begin
                int kind, lim, off;
                kind = $urandom_range(0, 7);
                lim  = (RN - 1 - i < 3) ? RN - 1 - i : 3;
                off  = $urandom_range(0, lim);
                case (kind)
                    0, 1: prog[i] = enc_r(fns[$urandom_range(0, 7)], $urandom_range(0, 7),
                                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
                    2:    prog[i] = enc_i(OP_ADDI, $urandom_range(0, 7), $urandom_range(0, 7),
                                          $urandom_range(0, 65535));
                    3:    prog[i] = enc_i(OP_SLTI, $urandom_range(0, 7), $urandom_range(0, 7),
                                          $urandom_range(0, 65535));
                    4:    prog[i] = enc_i(OP_LW, 0, $urandom_range(0, 7), rand_mem_off());
                    5:    prog[i] = enc_i(OP_SW, 0, $urandom_range(0, 7), rand_mem_off());
                    6:    prog[i] = enc_i(($urandom_range(0, 1) == 0) ? OP_BEQ : OP_BNE,
                                          $urandom_range(0, 7), $urandom_range(0, 7), off);
                    default: prog[i] = enc_j(i + 1 + off);
                endcase
            end
            prog[RN] = HALT_W;
            model_run();
            do_reset(); load_prog();
            run_prog(1'b0, 1000, done, b1);
            check($sformatf("rnd%0d_halted", r), 32'(halted), 32'd1);
            check($sformatf("rnd%0d_retired", r), retired, m_ret);
            check($sformatf("rnd%0d_cycles", r), cycles, m_cyc);
            check($sformatf("rnd%0d_pc", r), pc, m_pc);
            check($sformatf("rnd%0d_fault", r), 32'(fault), 32'(m_fault));
            for (int j = 1; j < 8; j++)
                check($sformatf("rnd%0d_reg%0d", r, j), dut.Reg_File[j], m_reg[j]);
            for (int j = 0; j < 16; j++)
                check($sformatf("rnd%0d_mem%0d", r, j), dut.Data_Mem[j], m_mem[j]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
